// File: rtl/aes_inv_cipher_pkg.sv
// Shared AES inverse-cipher types, constants and round helpers.
// Used by aes_inv_cipher and aes_inv_round.
package aes_parameters;

  localparam int AES_BLOCK_W = 128;
  localparam int MAX_ROUNDS  = 14;

  typedef logic [0:MAX_ROUNDS][AES_BLOCK_W-1:0] round_keys_t;

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  // byte (r + 4c) takes row r from column (c - r) mod 4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
      o[119-32*c -: 8] = mul9(a0) ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
      o[111-32*c -: 8] = mul13(a0) ^ mul9(a1) ^ mul14(a2) ^ mul11(a3);
      o[103-32*c -: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2) ^ mul14(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One registered AES inverse round; LAST skips InvMixColumns.
// Holds its contents whenever en is low.
module aes_inv_round
  import aes_parameters::*;
#(
  parameter bit LAST = 1'b0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [AES_BLOCK_W-1:0] rk,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   out_valid,
  output logic                   out_last
);

  logic [AES_BLOCK_W-1:0] ak;
  logic [AES_BLOCK_W-1:0] nx;

  assign ak = inv_sub_bytes(inv_shift_rows(in_data)) ^ rk;

  generate
    if (LAST) begin : g_last
      assign nx = ak;
    end else begin : g_mid
      assign nx = inv_mix_columns(ak);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (resetn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_data  <= nx;
      out_valid <= in_valid;
      out_last  <= in_last;
    end
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Fully pipelined AES inverse cipher, one stage per round.
// AES_INV_CIPHER_OUT_REG_EN adds an output register slice.
module aes_inv_cipher
  import aes_parameters::*;
#(
  parameter int ROUND_NUMBER = 14,
  parameter int TDATA_WIDTH  = 128
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [TDATA_WIDTH-1:0] aes_in_tdata,
  input  logic                   aes_in_tvalid,
  input  logic                   aes_in_tlast,
  output logic                   aes_in_tready,
  input  round_keys_t            round_keys,
  input  logic                   round_keys_valid,
  output logic [TDATA_WIDTH-1:0] aes_out_tdata,
  output logic                   aes_out_tvalid,
  output logic                   aes_out_tlast,
  input  logic                   aes_out_tready
);

  generate
    if (TDATA_WIDTH != AES_BLOCK_W) begin : g_bad_width
      $error("aes_inv_cipher: TDATA_WIDTH must be 128");
    end
    if (ROUND_NUMBER != 10 && ROUND_NUMBER != 12 &&
        ROUND_NUMBER != 14) begin : g_bad_rounds
      $error("aes_inv_cipher: ROUND_NUMBER must be 10, 12 or 14");
    end
  endgenerate

  logic                   adv;
  logic [AES_BLOCK_W-1:0] st_data  [0:ROUND_NUMBER];
  logic                   st_valid [0:ROUND_NUMBER];
  logic                   st_last  [0:ROUND_NUMBER];

  // the whole pipeline moves in lockstep with the output stage
  assign adv           = aes_out_tready | ~aes_out_tvalid;
  assign aes_in_tready = adv & round_keys_valid & ~resetn;

  always_ff @(posedge clk) begin
    if (resetn) begin
      st_data[0]  <= '0;
      st_valid[0] <= 1'b0;
      st_last[0]  <= 1'b0;
    end else if (adv) begin
      st_data[0]  <= aes_in_tdata ^ round_keys[ROUND_NUMBER];
      st_valid[0] <= aes_in_tvalid & aes_in_tready;
      st_last[0]  <= aes_in_tlast;
    end
  end

  generate
    for (genvar g = 1; g <= ROUND_NUMBER; g++) begin : g_round
      aes_inv_round #(
        .LAST (g == ROUND_NUMBER)
      ) u_round (
        .clk       (clk),
        .resetn    (resetn),
        .en        (adv),
        .in_data   (st_data[g-1]),
        .in_valid  (st_valid[g-1]),
        .in_last   (st_last[g-1]),
        .rk        (round_keys[ROUND_NUMBER-g]),
        .out_data  (st_data[g]),
        .out_valid (st_valid[g]),
        .out_last  (st_last[g])
      );
    end
  endgenerate

`ifdef AES_INV_CIPHER_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      aes_out_tdata  <= '0;
      aes_out_tvalid <= 1'b0;
      aes_out_tlast  <= 1'b0;
    end else if (adv) begin
      aes_out_tdata  <= st_data[ROUND_NUMBER];
      aes_out_tvalid <= st_valid[ROUND_NUMBER];
      aes_out_tlast  <= st_last[ROUND_NUMBER];
    end
  end
`else
  assign aes_out_tdata  = st_data[ROUND_NUMBER];
  assign aes_out_tvalid = st_valid[ROUND_NUMBER];
  assign aes_out_tlast  = st_last[ROUND_NUMBER];
`endif

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher using AES-256 ECB vectors.
// Round keys come from a local key expansion with a computed S-box.
module tb_aes_inv_cipher;
  import aes_parameters::*;

`ifdef AES_INV_CIPHER_OUT_REG_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 15;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [127:0] aes_in_tdata;
  logic        aes_in_tvalid;
  logic        aes_in_tlast;
  logic        aes_in_tready;
  round_keys_t round_keys;
  logic        round_keys_valid;
  logic [127:0] aes_out_tdata;
  logic        aes_out_tvalid;
  logic        aes_out_tlast;
  logic        aes_out_tready;

  int n_pass  = 0;
  int n_total = 0;

  logic [127:0] ct [4];
  logic [127:0] pt [4];
  logic [7:0]   sbox [256];
  logic [127:0] q_data [$];
  logic         q_last [$];

  always #5 clk = ~clk;

  aes_inv_cipher u_dut (
    .clk              (clk),
    .resetn           (resetn),
    .aes_in_tdata     (aes_in_tdata),
    .aes_in_tvalid    (aes_in_tvalid),
    .aes_in_tlast     (aes_in_tlast),
    .aes_in_tready    (aes_in_tready),
    .round_keys       (round_keys),
    .round_keys_valid (round_keys_valid),
    .aes_out_tdata    (aes_out_tdata),
    .aes_out_tvalid   (aes_out_tvalid),
    .aes_out_tlast    (aes_out_tlast),
    .aes_out_tready   (aes_out_tready)
  );

  always @(posedge clk)
    if (!resetn && aes_out_tvalid && aes_out_tready) begin
      q_data.push_back(aes_out_tdata);
      q_last.push_back(aes_out_tlast);
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] gx(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = gx(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^
                rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gx(rcon);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++)
      round_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!aes_out_tvalid && n < 60) begin
      tick;
      n++;
    end
    chk(tag, 128'(aes_out_tvalid), 128'd1);
  endtask

  task automatic wait_q(input int n, input string tag);
    int k = 0;
    while (q_data.size() < n && k < 100) begin
      tick;
      k++;
    end
    chk(tag, 128'(q_data.size()), 128'(n));
  endtask

  task automatic q_clear;
    q_data.delete();
    q_last.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    ct[0] = 128'hF3EED1BDB5D2A03C064B5A7E3DB181F8;
    ct[1] = 128'h591CCB10D410ED26DC5BA74A31362870;
    ct[2] = 128'hB6ED21B99CA6F4F9F153E7B1BEAFED1D;
    ct[3] = 128'h23304B7A39F9F3FF067D8D8F9E24ECC7;
    pt[0] = 128'h6BC1BEE22E409F96E93D7E117393172A;
    pt[1] = 128'hAE2D8A571E03AC9C9EB76FAC45AF8E51;
    pt[2] = 128'h30C81C46A35CE411E5FBC1191A0A52EF;
    pt[3] = 128'hF69F2445DF4F9B17AD2B417BE66C3710;

    resetn           = 1'b1;
    aes_in_tdata     = '0;
    aes_in_tvalid    = 1'b0;
    aes_in_tlast     = 1'b0;
    aes_out_tready   = 1'b1;
    round_keys       = '0;
    round_keys_valid = 1'b0;
    build_sbox();
    expand_key(256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4);
    round_keys_valid = 1'b1;
    repeat (3) tick;

    chk("rst_tvalid", 128'(aes_out_tvalid), 128'd0);
    chk("rst_tlast", 128'(aes_out_tlast), 128'd0);
    chk("rst_tdata", aes_out_tdata, 128'd0);
    chk("rst_in_tready", 128'(aes_in_tready), 128'd0);

    resetn = 1'b0;
    tick;
    chk("idle_in_tready", 128'(aes_in_tready), 128'd1);

    // single block, latency counted in edges including the handshake
    aes_in_tdata  = ct[0];
    aes_in_tvalid = 1'b1;
    tick;
    aes_in_tvalid = 1'b0;
    lat = 1;
    while (!aes_out_tvalid && lat < 40) begin
      tick;
      lat++;
    end
    chk("s1_latency", 128'(lat), 128'(LAT));
    chk("s1_data", aes_out_tdata, pt[0]);
    chk("s1_last", 128'(aes_out_tlast), 128'd0);
    repeat (2) tick;
    q_clear();

    // back-to-back burst of four
    for (int k = 0; k < 4; k++) begin
      aes_in_tdata  = ct[k];
      aes_in_tlast  = (k == 3);
      aes_in_tvalid = 1'b1;
      tick;
    end
    aes_in_tvalid = 1'b0;
    aes_in_tlast  = 1'b0;
    wait_out("s2_first");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s2_valid%0d", k), 128'(aes_out_tvalid), 128'd1);
      chk($sformatf("s2_data%0d", k), aes_out_tdata, pt[k]);
      chk($sformatf("s2_last%0d", k), 128'(aes_out_tlast), 128'(k == 3));
      tick;
    end
    chk("s2_no_extra", 128'(aes_out_tvalid), 128'd0);
    tick;
    q_clear();

    // backpressure mid-burst
    for (int k = 0; k < 4; k++) begin
      aes_in_tdata  = ct[k];
      aes_in_tlast  = (k == 3);
      aes_in_tvalid = 1'b1;
      tick;
    end
    aes_in_tvalid = 1'b0;
    aes_in_tlast  = 1'b0;
    wait_q(2, "s3_two_out");
    aes_out_tready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("s3_stall_valid%0d", k), 128'(aes_out_tvalid), 128'd1);
      chk($sformatf("s3_stall_data%0d", k), aes_out_tdata, pt[2]);
      chk($sformatf("s3_stall_rdy%0d", k), 128'(aes_in_tready), 128'd0);
      tick;
    end
    aes_out_tready = 1'b1;
    wait_q(4, "s3_four_out");
    repeat (LAT) tick;
    chk("s3_count", 128'(q_data.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s3_data%0d", k), q_data[k], pt[k]);
      chk($sformatf("s3_last%0d", k), 128'(q_last[k]), 128'(k == 3));
    end
    q_clear();

    // keys not valid: nothing accepted
    round_keys_valid = 1'b0;
    aes_in_tdata     = ct[0];
    aes_in_tvalid    = 1'b1;
    #1;
    chk("s4_rdy_low", 128'(aes_in_tready), 128'd0);
    repeat (LAT + 3) tick;
    chk("s4_rdy_still_low", 128'(aes_in_tready), 128'd0);
    chk("s4_no_out", 128'(q_data.size()), 128'd0);
    round_keys_valid = 1'b1;
    #1;
    chk("s4_rdy_high", 128'(aes_in_tready), 128'd1);
    tick;
    aes_in_tvalid = 1'b0;
    wait_q(1, "s4_out");
    chk("s4_data", q_data[0], pt[0]);
    repeat (2) tick;
    q_clear();

    // reset with two blocks in flight
    for (int k = 1; k < 3; k++) begin
      aes_in_tdata  = ct[k];
      aes_in_tvalid = 1'b1;
      tick;
    end
    aes_in_tvalid = 1'b0;
    repeat (3) tick;
    resetn = 1'b1;
    tick;
    resetn = 1'b0;
    chk("s5_tvalid_after_rst", 128'(aes_out_tvalid), 128'd0);
    repeat (LAT + 5) tick;
    chk("s5_no_stale", 128'(q_data.size()), 128'd0);
    aes_in_tdata  = ct[3];
    aes_in_tlast  = 1'b1;
    aes_in_tvalid = 1'b1;
    tick;
    aes_in_tvalid = 1'b0;
    aes_in_tlast  = 1'b0;
    wait_q(1, "s5_out");
    chk("s5_data", q_data[0], pt[3]);
    chk("s5_last", 128'(q_last[0]), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher.md
Name: aes_inv_cipher

Overview:
- Fully pipelined AES inverse cipher (decrypt) with AXI4-Stream-style 128-bit input and output.
- Consumes an expanded round-key schedule from the upstream key_expansion block.
- Accepts one block per clock; one pipeline stage per round.
- Sits between the ciphertext source and the plaintext sink in the AES-256 datapath.

Parameters:
- ROUND_NUMBER, 14, number of AES rounds; legal values are 10, 12 and 14; uses round_keys[0..ROUND_NUMBER].
- TDATA_WIDTH, 128, stream data width; only 128 is legal; elaboration error otherwise.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- resetn  in  1  synchronous, active-high reset (1 = reset asserted).
- aes_in_tdata  in  128  ciphertext block; bits [127:120] = byte 0, state column-major (byte i = row i%4, column i/4).
- aes_in_tvalid  in  1  input valid.
- aes_in_tlast  in  1  last block of packet; carried alongside its data.
- aes_in_tready  out  1  input ready.
- round_keys  in  round_keys_t  15 x 128-bit keys; round_keys[0] = first 128 key bits (w0..w3), round_keys[14] = last.
- round_keys_valid  in  1  key schedule complete and stable.
- aes_out_tdata  out  128  plaintext block, same byte order as input.
- aes_out_tvalid  out  1  output valid.
- aes_out_tlast  out  1  tlast of the corresponding input block.
- aes_out_tready  in  1  downstream ready.

Behaviour:
- Algorithm (FIPS-197 inverse cipher), with Nr = ROUND_NUMBER:
  - s = in ^ rk[Nr].
  - For r = Nr-1 down to 1: InvShiftRows, InvSubBytes, s ^= rk[r], InvMixColumns.
  - Final round: InvShiftRows, InvSubBytes, s ^= rk[0].
- Pipeline:
  - Stage 0 registers the initial AddRoundKey.
  - Stages 1..Nr each register one round.
  - Each stage carries a valid bit and a tlast bit.
- Global advance enable: adv = aes_out_tready | ~aes_out_tvalid. All stages shift together when adv = 1 and hold when adv = 0.
- aes_in_tready = adv & round_keys_valid & ~resetn. A transfer occurs when tvalid & tready.
- Stage-0 valid loads (tvalid & tready) on adv. Bubbles propagate as valid = 0.
- Latency: Nr+1 cycles from input handshake to aes_out_tvalid when unstalled, i.e. 15 for AES-256. Throughput: 1 block/cycle.
- Ordering preserved. aes_out_tlast equals the tlast of the same block.
- round_keys are used combinationally each cycle. The user keeps them stable while any block is in flight; no internal key copy.
- round_keys_valid low: no new input accepted; in-flight blocks still drain.
- Reset: all stage valid bits, aes_out_tvalid and aes_out_tlast = 0; aes_out_tdata = 0; in-flight data is discarded. Reset mid-stream drops all blocks, with no partial output.
- aes_out_tdata is held stable while aes_out_tvalid = 1 and aes_out_tready = 0.

Optional Feature:
- Macro AES_INV_CIPHER_OUT_REG_EN.
- Defined: an extra output register slice after the last round. Latency is Nr+2 (16 for AES-256). Full throughput is kept, with tready derived from that slice: it is ready when empty or downstream ready.
- Undefined: last round stage drives outputs directly; latency Nr+1.

Decomposition:
- Shared package (aes_parameters):
  - round_keys_t, a packed [0:14][127:0] array.
  - Constants AES_BLOCK_W = 128 and MAX_ROUNDS = 14.
  - Inverse S-box table and functions: inv_sub_bytes, inv_shift_rows, inv_mix_columns, and GF(2^8) xtime/multiply by 9, 11, 13, 14.
- One sub-module aes_inv_round:
  - Registered single round, with parameter LAST to skip InvMixColumns.
  - Ports: data, valid, last, round key, enable.
  - Instantiated Nr times via generate.

Test Plan:
1. Key 603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4 through key_expansion; after round_keys_valid, input F3EED1BDB5D2A03C064B5A7E3DB181F8 -> output 6BC1BEE22E409F96E93D7E117393172A, 15 cycles after the handshake.
2. Back-to-back burst, tvalid held 4 cycles (same key), inputs and required outputs:
   - 591CCB10D410ED26DC5BA74A31362870 -> AE2D8A571E03AC9C9EB76FAC45AF8E51
   - B6ED21B99CA6F4F9F153E7B1BEAFED1D -> 30C81C46A35CE411E5FBC1191A0A52EF
   - 23304B7A39F9F3FF067D8D8F9E24ECC7 with tlast=1 -> F69F2445DF4F9B17AD2B417BE66C3710 with aes_out_tlast=1 on the 4th output only.
   - Outputs on 4 consecutive cycles.
3. Backpressure: drop aes_out_tready for 5 cycles mid-burst -> aes_in_tready low while the output is stalled; no data lost or duplicated; output stable while stalled; order preserved.
4. round_keys_valid = 0 with tvalid = 1 -> aes_in_tready = 0, no output produced; accepted once keys are valid.
5. Assert resetn for 1 cycle with 2 blocks in flight -> aes_out_tvalid = 0 next cycle, no stale block ever emitted; the next input decrypts correctly.
6. With AES_INV_CIPHER_OUT_REG_EN defined, rerun scenario 1 -> same plaintext, latency 16.
